// File: rtl/act_lut_pkg.sv
`default_nettype none
// act_lut_pkg: shared defaults, mode constants, flag type and helpers for the LUT activation pipeline.
// Revision 1.0
package act_lut_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_LUT_SIZE   = 1537;
  localparam int DEF_STEP_SHIFT = 0;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic ACT_SIGMOID = 1'b0;
  localparam logic ACT_TANH    = 1'b1;

  typedef struct packed {
    logic sign;
    logic mode;
    logic sat;
  } act_flags_t;

  function automatic int act_one(input int frac_bits);
    return 1 << frac_bits;
  endfunction

  function automatic int act_max_in(input int lut_size, input int step_shift);
    return (lut_size - 1) << step_shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_addr_gen.sv
`default_nettype none
// act_addr_gen: |x|, range check and LUT address for one sample (combinational).
// Revision 1.0
module act_addr_gen
  import act_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LUT_SIZE   = DEF_LUT_SIZE,
  parameter int STEP_SHIFT = DEF_STEP_SHIFT
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_sign,
  output logic                  o_sat,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  localparam int                  C_EXT_W  = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] C_MAX_IN = C_EXT_W'(act_max_in(LUT_SIZE, STEP_SHIFT));
  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(LUT_SIZE - 1);

  logic [DATA_WIDTH:0] w_ext;
  logic [DATA_WIDTH:0] w_abs;
  logic [DATA_WIDTH:0] w_shift;
  logic                w_unused;

  // One extra bit so the most negative input becomes a positive magnitude and saturates.
  assign o_sign   = i_data[DATA_WIDTH-1];
  assign w_ext    = {i_data[DATA_WIDTH-1], i_data};
  assign w_abs    = o_sign ? -w_ext : w_ext;
  assign o_sat    = (w_abs > C_MAX_IN);
  assign w_shift  = w_abs >> STEP_SHIFT;
  assign o_addr   = o_sat ? C_LAST : w_shift[ADDR_WIDTH-1:0];
  assign w_unused = ^w_shift[DATA_WIDTH:ADDR_WIDTH];

endmodule
`default_nettype wire

// File: rtl/act_lut_pipe.sv
`default_nettype none
// act_lut_pipe: pipelined sigmoid/tanh LUT activation with valid/ready handshake and saturation count.
// Revision 1.0
module act_lut_pipe
  import act_lut_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LUT_SIZE   = DEF_LUT_SIZE,
  parameter int STEP_SHIFT = DEF_STEP_SHIFT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  lut_rd_en,
  output logic                  lut_sel,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  sat_count,
  input  logic                  sat_clr
);

  localparam logic [DATA_WIDTH-1:0] C_ONE = DATA_WIDTH'(act_one(FRAC_BITS));

  logic                  w_sign;
  logic                  w_sat;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_b_ready;
  logic                  w_r_leave;
  logic [2:0]            w_occ;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_y;
  logic [DATA_WIDTH-1:0] w_result;

  // Stage A: sample whose ROM read is being issued this cycle.
  logic                  r_a_full;
  act_flags_t            r_a_flags;
  logic                  r_lut_sel;
  logic [ADDR_WIDTH-1:0] r_lut_addr;

  // Read-data slots: r_r0 is the oldest; with two entries its word lives in r_hold.
  logic [1:0]            r_r_cnt;
  act_flags_t            r_r0;
  act_flags_t            r_r1;
  logic [DATA_WIDTH-1:0] r_hold;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]  r_sat_count;

  act_addr_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LUT_SIZE   (LUT_SIZE),
    .STEP_SHIFT (STEP_SHIFT)
  ) u_addr_gen (
    .i_data (in_data),
    .o_sign (w_sign),
    .o_sat  (w_sat),
    .o_addr (w_addr)
  );

  assign w_b_ready = ~r_out_valid | out_ready;
  assign w_r_leave = (r_r_cnt != 2'd0) & w_b_ready;
  // Accept only if the new read will find a free slot when its data lands next cycle.
  assign w_occ     = {1'b0, r_r_cnt} + {2'b00, r_a_full} - {2'b00, w_r_leave};
  assign in_ready  = (w_occ <= 3'd1);
  assign w_accept  = in_valid & in_ready;

  assign lut_rd_en = r_a_full;
  assign lut_sel   = r_lut_sel;
  assign lut_addr  = r_lut_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_count = r_sat_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_full   <= 1'b0;
      r_a_flags  <= '0;
      r_lut_sel  <= 1'b0;
      r_lut_addr <= '0;
    end else begin
      r_a_full <= w_accept;
      if (w_accept) begin
        r_a_flags.sign <= w_sign;
        r_a_flags.mode <= in_mode;
        r_a_flags.sat  <= w_sat;
        r_lut_sel      <= in_mode;
        r_lut_addr     <= w_addr;
      end
    end
  end

  // The ROM overwrites its output on every read, so a waiting word is copied to r_hold first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_cnt <= 2'd0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_hold  <= '0;
    end else begin
      case ({w_r_leave, r_a_full})
        2'b01: begin
          if (r_r_cnt == 2'd0) begin
            r_r0 <= r_a_flags;
          end else begin
            r_r1   <= r_a_flags;
            r_hold <= lut_rd_data;
          end
          r_r_cnt <= r_r_cnt + 2'd1;
        end
        2'b10: begin
          r_r0    <= r_r1;
          r_r_cnt <= r_r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_r_cnt == 2'd1) begin
            r_r0 <= r_a_flags;
          end else begin
            r_r0   <= r_r1;
            r_r1   <= r_a_flags;
            r_hold <= lut_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_y = (r_r_cnt == 2'd2) ? r_hold : lut_rd_data;

  always_comb begin
    w_result = w_y;
    if (r_r0.mode == ACT_TANH) begin
      if (r_r0.sat) begin
        w_result = r_r0.sign ? -C_ONE : C_ONE;
      end else if (r_r0.sign) begin
        w_result = -w_y;
      end
    end else begin
      if (r_r0.sat) begin
        w_result = r_r0.sign ? '0 : C_ONE;
      end else if (r_r0.sign) begin
        w_result = C_ONE - w_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_r_leave) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_r_leave && r_r0.sat && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_act_lut_pipe.sv
`default_nettype none
// tb_act_lut_pipe: randomized and directed self-checking bench for act_lut_pipe.
// Revision 1.0
module tb_act_lut_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_mode;
  logic        out_ready;
  logic        sat_clr;
  logic [15:0] rom_q;

  logic        in_ready, lut_rd_en, lut_sel, out_valid;
  logic [10:0] lut_addr;
  logic [15:0] out_data, sat_count;

  logic        s_in_ready, s_lut_rd_en, s_lut_sel, s_out_valid;
  logic [10:0] s_lut_addr;
  logic [15:0] s_out_data;
  logic [2:0]  s_sat_count;

  logic [15:0] sig_tbl  [0:1536];
  logic [15:0] tanh_tbl [0:1536];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  act_lut_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .lut_rd_en(lut_rd_en), .lut_sel(lut_sel),
    .lut_addr(lut_addr), .lut_rd_data(rom_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  act_lut_pipe #(.CNT_WIDTH(3)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode), .lut_rd_en(s_lut_rd_en), .lut_sel(s_lut_sel),
    .lut_addr(s_lut_addr), .lut_rd_data(rom_q), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .sat_count(s_sat_count), .sat_clr(sat_clr)
  );

  // Synchronous-read ROM: output changes only on a read strobe.
  always @(posedge clk) begin
    if (lut_rd_en) rom_q <= lut_sel ? tanh_tbl[lut_addr] : sig_tbl[lut_addr];
  end

  function automatic int abs_of(input logic [15:0] x);
    int xi;
    xi = int'($signed(x));
    return (xi < 0) ? -xi : xi;
  endfunction

  function automatic logic [15:0] model_out(input logic [15:0] x, input logic m);
    int ax, y, r;
    bit neg;
    neg = x[15];
    ax  = abs_of(x);
    if (ax > 1536) begin
      if (m) r = neg ? -256 : 256;
      else   r = neg ? 0 : 256;
    end else begin
      y = m ? int'(tanh_tbl[ax]) : int'(sig_tbl[ax]);
      if (m) r = neg ? -y : y;
      else   r = neg ? 256 - y : y;
    end
    return r[15:0];
  endfunction

  function automatic logic [10:0] model_addr(input logic [15:0] x);
    int ax;
    ax = abs_of(x);
    if (ax > 1536) ax = 1536;
    return ax[10:0];
  endfunction

  task automatic send_single(input logic [15:0] x, input logic m, input logic [10:0] ea,
                             input logic [15:0] eo, input string nm);
    @(negedge clk);
    in_valid = 1'b1; in_data = x; in_mode = m; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (lut_rd_en !== 1'b1 || lut_addr !== ea || lut_sel !== m || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rom_req: got en=%b addr=%h sel=%b ov=%b want en=1 addr=%h sel=%b ov=0",
               nm, lut_rd_en, lut_addr, lut_sel, out_valid, ea, m);
    end
    @(negedge clk);
    checks++;
    if (lut_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s early: got en=%b ov=%b want en=0 ov=0", nm, lut_rd_en, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== eo) begin
      errors++; $display("FAIL %s result: got ov=%b data=%h want ov=1 data=%h", nm, out_valid, out_data, eo);
    end
  endtask

  task automatic clear_count;
    @(negedge clk); sat_clr = 1'b1;
    @(negedge clk); sat_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || lut_rd_en !== 1'b0 || lut_sel !== 1'b0 || lut_addr !== 11'h0) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b en=%b sel=%b addr=%h want 1 0 0 000", in_ready, lut_rd_en, lut_sel, lut_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || sat_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_b: got ov=%b data=%h cnt=%h want 0 0000 0000", out_valid, out_data, sat_count);
    end
  endtask

  task automatic test_directed;
    send_single(16'h0100, 1'b0, 11'h100, 16'h00BB, "sig_pos1");
    send_single(16'hFF00, 1'b0, 11'h100, 16'h0045, "sig_neg1");
    send_single(16'hFF00, 1'b1, 11'h100, 16'hFF3D, "tanh_neg1");
    send_single(16'h0000, 1'b0, 11'h000, sig_tbl[0], "zero_in");
  endtask

  task automatic test_saturation;
    clear_count();
    send_single(16'h0601, 1'b0, 11'h600, 16'h0100, "sat_sig");
    send_single(16'h8000, 1'b1, 11'h600, 16'hFF00, "sat_tanh_min");
    send_single(16'h0600, 1'b0, 11'h600, 16'h00FE, "edge_max_in");
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd2) begin
      errors++; $display("FAIL sat_count: got %0d want 2", sat_count);
    end
  endtask

  task automatic test_sat_clr;
    clear_count();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h7000; in_mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0100 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority: got ov=%b data=%h cnt=%0d want 1 0100 0", out_valid, out_data, sat_count);
    end
    send_single(16'h9000, 1'b1, 11'h600, 16'hFF00, "sat_after_clr");
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd1) begin
      errors++; $display("FAIL count_after_clr: got %0d want 1", sat_count);
    end
  endtask

  task automatic test_counter_hold;
    int n_acc;
    clear_count();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0700; in_mode = 1'b0; out_ready = 1'b1;
      #1;
      if (in_ready) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (n_acc !== 10) begin
      errors++; $display("FAIL stream_accept: got %0d accepted want 10", n_acc);
    end
    checks++;
    if (sat_count !== 16'd10 || s_sat_count !== 3'd7) begin
      errors++; $display("FAIL cnt_hold: got cnt=%0d small=%0d want 10 7", sat_count, s_sat_count);
    end
    send_single(16'hF800, 1'b1, 11'h600, 16'hFF00, "sat_over_top");
    @(negedge clk);
    checks++;
    if (s_sat_count !== 3'd7 || sat_count !== 16'd11) begin
      errors++; $display("FAIL cnt_saturate: got small=%0d cnt=%0d want 7 11", s_sat_count, sat_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    logic [11:0] req_q[$];
    logic [15:0] x, held, e;
    logic [11:0] er;
    logic        m, stalled;
    int sent, recv, pulses, cyc, sel;
    sent = 0; recv = 0; pulses = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (recv < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (lut_rd_en) begin
        pulses++;
        checks++;
        if (req_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_read: addr=%h with no pending sample", lut_addr);
        end else begin
          er = req_q.pop_front();
          if ({lut_sel, lut_addr} !== er) begin
            errors++; $display("FAIL b2b_read: got sel=%b addr=%h want sel=%b addr=%h", lut_sel, lut_addr, er[11], er[10:0]);
          end
        end
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL b2b_stall: got ov=%b data=%h want 1 %h", out_valid, out_data, held);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 64) && ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       x = 16'($urandom);
        1:       x = 16'($urandom_range(0, 1536));
        2:       x = 16'(-int'($urandom_range(0, 1536)));
        default: x = 16'(int'($urandom_range(1530, 1545)) * ($urandom_range(0, 1) ? -1 : 1));
      endcase
      m = 1'($urandom_range(0, 1));
      in_data = x; in_mode = m;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model_out(x, m));
        req_q.push_back({m, model_addr(x)});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_out: data=%h with nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++; $display("FAIL b2b_data #%0d: got %h want %h", recv, out_data, e);
          end
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (recv !== 64 || pulses !== 64 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_totals: got recv=%0d reads=%0d ov=%b left=%0d want 64 64 0 0", recv, pulses, out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight;
    int cyc, stale;
    cyc = 0;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100; in_mode = 1'b0;
    #1;
    while (in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL fill: got rdy=%b ov=%b want 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || lut_rd_en !== 1'b0) begin
      errors++; $display("FAIL rst_async: got ov=%b en=%b want 0 0", out_valid, lut_rd_en);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || lut_rd_en !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_stale: got %0d active cycles want 0", stale);
    end
    send_single(16'hFF00, 1'b0, 11'h100, 16'h0045, "after_rst");
  endtask

  initial begin
    for (int i = 0; i <= 1536; i++) begin
      sig_tbl[i]  = 16'($urandom_range(0, 256));
      tanh_tbl[i] = 16'($urandom_range(0, 256));
    end
    sig_tbl[256]  = 16'h00BB;
    tanh_tbl[256] = 16'h00C3;
    sig_tbl[1536] = 16'h00FE;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;

    test_reset();
    test_directed();
    test_saturation();
    test_sat_clr();
    test_counter_hold();
    test_back_to_back();
    test_reset_midflight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
